// File: rtl/conv_wb_sched_pkg.sv
// Shared constants and FSM encoding for the conv output write-back scheduler.
package conv_wb_sched_pkg;
  localparam int CH_NUM       = 24;
  localparam int ACT_PER_ADDR = 4;
  localparam int BW_PER_ACT   = 16;
  localparam int MASK_W       = CH_NUM * ACT_PER_ADDR;
  localparam int CH_W         = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;
endpackage

// File: rtl/conv_wb_sched_mask_decode.sv
// Active-low single-lane byte mask from (ch, pos); combinational, no backpressure.
// Lane order puts ch 0 / pos 0 in the MSB; out-of-range channels produce no write.
module wb_mask_decode #(
  parameter int CH_NUM       = conv_wb_sched_pkg::CH_NUM,
  parameter int ACT_PER_ADDR = conv_wb_sched_pkg::ACT_PER_ADDR,
  parameter int CH_W         = conv_wb_sched_pkg::CH_W,
  parameter int POS_W        = 2
) (
  input  logic [CH_W-1:0]                ch_i,
  input  logic [POS_W-1:0]               pos_i,
  input  logic                           vld_i,
  output logic [CH_NUM*ACT_PER_ADDR-1:0] mask_o
);
  int zero_idx;

  always_comb begin
    mask_o   = '1;
    zero_idx = (CH_NUM - 1 - int'(ch_i)) * ACT_PER_ADDR + (ACT_PER_ADDR - 1 - int'(pos_i));
    if (vld_i && (int'(ch_i) < CH_NUM) && (int'(pos_i) < ACT_PER_ADDR)) begin
      for (int i = 0; i < CH_NUM * ACT_PER_ADDR; i++) begin
        if (i == zero_idx) mask_o[i] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/conv_wb_sched.sv
// Walks (row, col, ch), issues PE requests and turns returning results into
// single-activation SRAM writes PIPE_LAT cycles later; stalls only insert bubbles.
module conv_wb_sched #(
  parameter int CH_NUM       = conv_wb_sched_pkg::CH_NUM,
  parameter int ACT_PER_ADDR = conv_wb_sched_pkg::ACT_PER_ADDR,
  parameter int BW_PER_ACT   = conv_wb_sched_pkg::BW_PER_ACT,
  parameter int FMAP_H       = 28,
  parameter int FMAP_W       = 28,
  parameter int PIPE_LAT     = 5,
  parameter int ADDR_W       = 10
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      issue_valid,
  input  logic                                      issue_ready,
  output logic [6:0]                                issue_ch,
  input  logic [BW_PER_ACT-1:0]                     pe_result,
  output logic                                      sram_wen,
  output logic [ADDR_W-1:0]                         sram_waddr,
  output logic [CH_NUM*ACT_PER_ADDR*BW_PER_ACT-1:0] sram_wdata,
  output logic [CH_NUM*ACT_PER_ADDR-1:0]            sram_bytemask,
  output logic                                      busy,
  output logic                                      done
);
  import conv_wb_sched_pkg::*;

  localparam int LANES = CH_NUM * ACT_PER_ADDR;
  localparam int CNT_W = 8;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] waddr_q;

  logic [PIPE_LAT-1:0] vld_q;
  logic [CH_W-1:0]     dch_q   [PIPE_LAT];
  logic [ADDR_W-1:0]   daddr_q [PIPE_LAT];
  logic [1:0]          dpos_q  [PIPE_LAT];

  logic              accept, last_tuple, wr_vld;
  logic [ADDR_W-1:0] issue_addr;

  assign accept     = (state_q == ISSUE) && issue_ready;
  assign last_tuple = (ch_q == CH_W'(CH_NUM - 1)) && (row_q == CNT_W'(FMAP_H - 1)) &&
                      (col_q == CNT_W'(FMAP_W - 1));
  // One SRAM word holds a 2x2 pixel quad, so the address is the quad index.
  assign issue_addr = ADDR_W'(32'(row_q >> 1) * 32'(FMAP_W / 2) + 32'(col_q >> 1));
  assign wr_vld     = vld_q[PIPE_LAT-1];

  always_comb begin
    state_d     = state_q;
    issue_valid = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        issue_valid = 1'b1;
        busy        = 1'b1;
        if (accept && last_tuple) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (vld_q == '0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d  = ch_q;
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE && start) begin
      ch_d  = '0;
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (ch_q == CH_W'(CH_NUM - 1)) begin
        ch_d = '0;
        if (col_q == CNT_W'(FMAP_W - 1)) begin
          col_d = '0;
          row_d = (row_q == CNT_W'(FMAP_H - 1)) ? '0 : row_q + CNT_W'(1);
        end else begin
          col_d = col_q + CNT_W'(1);
        end
      end else begin
        ch_d = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      waddr_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dch_q[i]   <= '0;
        daddr_q[i] <= '0;
        dpos_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      row_q      <= row_d;
      col_q      <= col_d;
      // The tag line shifts every cycle; a refused issue becomes a bubble.
      vld_q      <= {vld_q[PIPE_LAT-2:0], accept};
      dch_q[0]   <= ch_q;
      daddr_q[0] <= issue_addr;
      dpos_q[0]  <= {row_q[0], col_q[0]};
      for (int i = 1; i < PIPE_LAT; i++) begin
        dch_q[i]   <= dch_q[i-1];
        daddr_q[i] <= daddr_q[i-1];
        dpos_q[i]  <= dpos_q[i-1];
      end
      if (wr_vld) waddr_q <= daddr_q[PIPE_LAT-1];
    end
  end

  assign issue_ch   = ch_q;
  assign sram_wen   = ~wr_vld;
  assign sram_waddr = wr_vld ? daddr_q[PIPE_LAT-1] : waddr_q;
  assign sram_wdata = {LANES{pe_result}};

  wb_mask_decode #(
    .CH_NUM      (CH_NUM),
    .ACT_PER_ADDR(ACT_PER_ADDR),
    .CH_W        (CH_W),
    .POS_W       (2)
  ) u_mask (
    .ch_i  (dch_q[PIPE_LAT-1]),
    .pos_i (dpos_q[PIPE_LAT-1]),
    .vld_i (wr_vld),
    .mask_o(sram_bytemask)
  );
endmodule
